// File: rtl/seg14_pkg.sv
// Shared constants and 14-segment font for the display scan bus.
// Segment order, MSB first: a b c d e f g1 g2 h i j k l m.
package seg14_pkg;

  localparam int DIGITS     = 12;
  localparam int SEG_W      = 14;
  localparam int CODE_W     = 6;
  localparam int NUM_GLYPHS = 38;

  localparam logic [CODE_W-1:0] CODE_SPACE   = 6'd0;
  localparam logic [CODE_W-1:0] CODE_UNKNOWN = 6'd63;

  typedef enum logic {ST_HUNT, ST_CAPTURE} state_t;

  // Index is the character code; 5 shares the S glyph.
  function automatic logic [SEG_W-1:0] font_glyph(input logic [CODE_W-1:0] c);
    case (c)
      6'd0:  font_glyph = 14'b000000_00_000000; // space
      6'd1:  font_glyph = 14'b111011_11_000000; // A
      6'd2:  font_glyph = 14'b111100_01_010010; // B
      6'd3:  font_glyph = 14'b100111_00_000000; // C
      6'd4:  font_glyph = 14'b111100_00_010010; // D
      6'd5:  font_glyph = 14'b100111_10_000000; // E
      6'd6:  font_glyph = 14'b100011_10_000000; // F
      6'd7:  font_glyph = 14'b101111_01_000000; // G
      6'd8:  font_glyph = 14'b011011_11_000000; // H
      6'd9:  font_glyph = 14'b100100_00_010010; // I
      6'd10: font_glyph = 14'b011110_00_000000; // J
      6'd11: font_glyph = 14'b000011_10_001001; // K
      6'd12: font_glyph = 14'b000111_00_000000; // L
      6'd13: font_glyph = 14'b011011_00_101000; // M
      6'd14: font_glyph = 14'b011011_00_100001; // N
      6'd15: font_glyph = 14'b111111_00_000000; // O
      6'd16: font_glyph = 14'b110011_11_000000; // P
      6'd17: font_glyph = 14'b111111_00_000001; // Q
      6'd18: font_glyph = 14'b110011_11_000001; // R
      6'd19: font_glyph = 14'b101101_11_000000; // S
      6'd20: font_glyph = 14'b100000_00_010010; // T
      6'd21: font_glyph = 14'b011111_00_000000; // U
      6'd22: font_glyph = 14'b000011_00_001100; // V
      6'd23: font_glyph = 14'b011011_00_000101; // W
      6'd24: font_glyph = 14'b000000_00_101101; // X
      6'd25: font_glyph = 14'b000000_00_101010; // Y
      6'd26: font_glyph = 14'b100100_00_001100; // Z
      6'd27: font_glyph = 14'b111011_00_100001; // N tilde
      6'd28: font_glyph = 14'b111111_00_001100; // 0
      6'd29: font_glyph = 14'b011000_00_001000; // 1
      6'd30: font_glyph = 14'b110110_11_000000; // 2
      6'd31: font_glyph = 14'b111100_01_000000; // 3
      6'd32: font_glyph = 14'b011001_11_000000; // 4
      6'd33: font_glyph = 14'b101101_11_000000; // 5
      6'd34: font_glyph = 14'b101111_11_000000; // 6
      6'd35: font_glyph = 14'b111000_00_000000; // 7
      6'd36: font_glyph = 14'b111111_11_000000; // 8
      6'd37: font_glyph = 14'b111101_11_000000; // 9
      default: font_glyph = '0;
    endcase
  endfunction

endpackage

// File: rtl/seg14_glyph_decode.sv
// Combinational segment pattern -> character code lookup, exact match only.
// Zero latency; lowest matching code wins, so the shared S/5 glyph gives S.
module seg14_glyph_decode
  import seg14_pkg::*;
(
  input  logic [SEG_W-1:0]  segm,
  output logic [CODE_W-1:0] code
);

  always_comb begin
    code = CODE_UNKNOWN;
    for (int i = NUM_GLYPHS - 1; i >= 0; i--) begin
      if (segm == font_glyph(CODE_W'(i))) code = CODE_W'(i);
    end
  end

endmodule

// File: rtl/seg14_scan_decoder.sv
// Scan-bus monitor: decodes glyphs, checks digit order, commits whole frames.
// Input sampled at edge N produces strobes at edge N+2; no backpressure.
module seg14_scan_decoder #(
  parameter int DIGITS = seg14_pkg::DIGITS,
  parameter int SEG_W  = seg14_pkg::SEG_W,
  parameter int CODE_W = seg14_pkg::CODE_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DIGITS-1:0] sel,
  input  logic [SEG_W-1:0]  segm,
  output logic              char_valid,
  output logic [3:0]        char_idx,
  output logic [CODE_W-1:0] char_code,
  output logic              frame_done,
  output logic              frame_ok,
  output logic              err_onehot,
  output logic              err_seq,
  output logic [7:0]        frame_cnt,
  input  logic [3:0]        rd_idx,
  output logic [CODE_W-1:0] rd_code
);
  import seg14_pkg::*;

  localparam logic [3:0] LAST_IDX = 4'(DIGITS - 1);

  logic [DIGITS-1:0] sel_q;
  logic [SEG_W-1:0]  segm_q;
  logic              s1_onehot, s1_bad;
  logic [3:0]        s1_idx;
  logic [CODE_W-1:0] s1_code;
  logic              k_vld, k_bad;
  logic [3:0]        k_idx;
  logic [CODE_W-1:0] k_code;

  state_t            state_q, state_d;
  logic [3:0]        last_q, last_d;
  logic              wr_en, commit_en, seq_err, frame_ok_nx;
  logic [CODE_W-1:0] shadow_q [DIGITS];
  logic [CODE_W-1:0] shadow_nx [DIGITS];
  logic [CODE_W-1:0] commit_q [DIGITS];

  seg14_glyph_decode u_dec (.segm(segm_q), .code(s1_code));

  always_comb begin
    s1_onehot = (sel_q != '0) && ((sel_q & (sel_q - DIGITS'(1))) == '0);
    s1_bad    = (sel_q != '0) && !s1_onehot;
    s1_idx    = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (sel_q[i]) s1_idx = 4'(i);
    end
  end

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    wr_en     = 1'b0;
    commit_en = 1'b0;
    seq_err   = 1'b0;
    if (k_bad) begin
      state_d = ST_HUNT;
    end else if (k_vld) begin
      case (state_q)
        ST_HUNT: begin
          if (k_idx == 4'd0) begin
            wr_en   = 1'b1;
            last_d  = 4'd0;
            state_d = ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          if (k_idx == last_q) begin
            wr_en = 1'b1;
          end else if (k_idx == last_q + 4'd1) begin
            wr_en  = 1'b1;
            last_d = k_idx;
            if (k_idx == LAST_IDX) begin
              commit_en = 1'b1;
              state_d   = ST_HUNT;
            end
          end else begin
            seq_err = 1'b1;
            state_d = ST_HUNT;
          end
        end
        default: state_d = ST_HUNT;
      endcase
    end
  end

  // The digit-11 write must land in the same cycle it is committed.
  always_comb begin
    shadow_nx = shadow_q;
    if (wr_en) shadow_nx[k_idx] = k_code;
    frame_ok_nx = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (shadow_nx[i] == CODE_UNKNOWN) frame_ok_nx = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q      <= '0;
      segm_q     <= '0;
      k_vld      <= 1'b0;
      k_bad      <= 1'b0;
      k_idx      <= '0;
      k_code     <= CODE_SPACE;
      state_q    <= ST_HUNT;
      last_q     <= '0;
      char_valid <= 1'b0;
      char_idx   <= '0;
      char_code  <= CODE_SPACE;
      frame_done <= 1'b0;
      frame_ok   <= 1'b0;
      err_onehot <= 1'b0;
      err_seq    <= 1'b0;
      frame_cnt  <= '0;
      for (int i = 0; i < DIGITS; i++) begin
        shadow_q[i] <= CODE_SPACE;
        commit_q[i] <= CODE_SPACE;
      end
    end else begin
      sel_q      <= sel;
      segm_q     <= segm;
      k_vld      <= s1_onehot;
      k_bad      <= s1_bad;
      k_idx      <= s1_idx;
      k_code     <= s1_code;
      state_q    <= state_d;
      last_q     <= last_d;
      shadow_q   <= shadow_nx;
      char_valid <= k_vld;
      err_onehot <= k_bad;
      err_seq    <= seq_err;
      frame_done <= commit_en;
      if (k_vld) begin
        char_idx  <= k_idx;
        char_code <= k_code;
      end
      if (commit_en) begin
        commit_q  <= shadow_nx;
        frame_ok  <= frame_ok_nx;
        frame_cnt <= frame_cnt + 8'd1;
      end
    end
  end

  assign rd_code = (rd_idx < 4'(DIGITS)) ? commit_q[rd_idx] : '0;

endmodule

// File: tb/tb_seg14_scan_decoder.sv
// Scoreboard bench: stimulus feeds a frame-level reference model that queues
// expected strobes; a monitor pops and compares whenever the DUT strobes.
module tb_seg14_scan_decoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] sel = '0;
  logic [13:0] segm = '0;
  logic [3:0]  rd_idx = '0;
  logic        char_valid, frame_done, frame_ok, err_onehot, err_seq;
  logic [3:0]  char_idx;
  logic [5:0]  char_code, rd_code;
  logic [7:0]  frame_cnt;

  always #5 clk = ~clk;

  seg14_scan_decoder dut (
    .clk(clk), .rst_n(rst_n), .sel(sel), .segm(segm),
    .char_valid(char_valid), .char_idx(char_idx), .char_code(char_code),
    .frame_done(frame_done), .frame_ok(frame_ok), .err_onehot(err_onehot),
    .err_seq(err_seq), .frame_cnt(frame_cnt), .rd_idx(rd_idx), .rd_code(rd_code)
  );

  typedef struct packed {
    logic            cv;
    logic [3:0]      idx;
    logic [5:0]      code;
    logic            fd;
    logic            ok;
    logic            eoh;
    logic            esq;
    logic [7:0]      cnt;
    logic [11:0][5:0] comm;
  } ev_t;

  ev_t         expq[$];
  int          total = 0;
  int          bad = 0;
  int          n_cv = 0, n_fd = 0, n_eoh = 0, n_esq = 0;
  logic [13:0] font [38];
  logic [13:0] fp [12];

  // Reference model state
  bit          m_cap;
  int          m_last;
  int          m_shadow [12];
  int          m_comm [12];
  logic        m_ok;
  logic [7:0]  m_cnt;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int decode(input logic [13:0] p);
    for (int i = 0; i < 38; i++) if (font[i] == p) return i;
    return 63;
  endfunction

  task automatic model_reset;
    m_cap = 1'b0; m_last = 0; m_ok = 1'b0; m_cnt = '0;
    for (int i = 0; i < 12; i++) begin m_shadow[i] = 0; m_comm[i] = 0; end
    expq.delete();
  endtask

  task automatic model_step(input logic [11:0] s, input logic [13:0] p);
    ev_t e;
    int  k, code;
    if (s == '0) return;
    e = '0;
    if ($countones(s) != 1) begin
      e.eoh = 1'b1;
      m_cap = 1'b0;
    end else begin
      k = 0;
      for (int i = 0; i < 12; i++) if (s[i]) k = i;
      code   = decode(p);
      e.cv   = 1'b1;
      e.idx  = k[3:0];
      e.code = code[5:0];
      if (!m_cap) begin
        if (k == 0) begin m_shadow[0] = code; m_last = 0; m_cap = 1'b1; end
      end else if (k == m_last) begin
        m_shadow[k] = code;
      end else if (k == m_last + 1) begin
        m_shadow[k] = code;
        m_last = k;
        if (k == 11) begin
          m_comm = m_shadow;
          m_cnt++;
          m_ok = 1'b1;
          for (int i = 0; i < 12; i++) if (m_comm[i] == 63) m_ok = 1'b0;
          e.fd  = 1'b1;
          m_cap = 1'b0;
        end
      end else begin
        e.esq = 1'b1;
        m_cap = 1'b0;
      end
    end
    e.ok  = m_ok;
    e.cnt = m_cnt;
    for (int i = 0; i < 12; i++) e.comm[i] = 6'(m_comm[i]);
    expq.push_back(e);
  endtask

  task automatic drive(input logic [11:0] s, input logic [13:0] p);
    @(negedge clk);
    sel    = s;
    segm   = p;
    rd_idx = 4'($urandom_range(0, 15));
    model_step(s, p);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive('0, '0);
  endtask

  task automatic send_frame(input int hold, input int gap_after);
    for (int d = 0; d < 12; d++) begin
      for (int h = 0; h < hold; h++) drive(12'(1 << d), fp[d]);
      if (d == gap_after) drive('0, '0);
    end
  endtask

  task automatic load_chars(input int c [12]);
    for (int d = 0; d < 12; d++) fp[d] = font[c[d]];
  endtask

  task automatic do_reset;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    sel   = '0;
    segm  = '0;
    model_reset();
    #1;
    chk("rst_strobes", {char_valid, frame_done, err_onehot, err_seq}, 0);
    chk("rst_char", {char_idx, char_code}, 0);
    chk("rst_frame_ok", frame_ok, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    for (int i = 0; i < 16; i++) begin
      rd_idx = 4'(i);
      #1;
      chk("rst_rd_code", rd_code, 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: one expected event per strobing output cycle
  initial begin
    ev_t e;
    int  exp_rd;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && (char_valid || frame_done || err_onehot || err_seq)) begin
        n_cv  += int'(char_valid);
        n_fd  += int'(frame_done);
        n_eoh += int'(err_onehot);
        n_esq += int'(err_seq);
        if (expq.size() == 0) begin
          chk("unexpected_strobe", {char_valid, frame_done, err_onehot, err_seq}, 0);
        end else begin
          e = expq.pop_front();
          chk("char_valid", char_valid, e.cv);
          chk("frame_done", frame_done, e.fd);
          chk("err_onehot", err_onehot, e.eoh);
          chk("err_seq", err_seq, e.esq);
          if (e.cv) begin
            chk("char_idx", char_idx, e.idx);
            chk("char_code", char_code, e.code);
          end
          chk("frame_ok", frame_ok, e.ok);
          chk("frame_cnt", frame_cnt, e.cnt);
          exp_rd = (rd_idx < 12) ? int'(e.comm[rd_idx]) : 0;
          chk("rd_code", rd_code, exp_rd);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int nom [12];
    int good [12];
    int c0, c1, c2, c3;
    int hold, mode, c;
    logic [13:0] p;

    font = '{
      14'b000000_00_000000, 14'b111011_11_000000, 14'b111100_01_010010, 14'b100111_00_000000,
      14'b111100_00_010010, 14'b100111_10_000000, 14'b100011_10_000000, 14'b101111_01_000000,
      14'b011011_11_000000, 14'b100100_00_010010, 14'b011110_00_000000, 14'b000011_10_001001,
      14'b000111_00_000000, 14'b011011_00_101000, 14'b011011_00_100001, 14'b111111_00_000000,
      14'b110011_11_000000, 14'b111111_00_000001, 14'b110011_11_000001, 14'b101101_11_000000,
      14'b100000_00_010010, 14'b011111_00_000000, 14'b000011_00_001100, 14'b011011_00_000101,
      14'b000000_00_101101, 14'b000000_00_101010, 14'b100100_00_001100, 14'b111011_00_100001,
      14'b111111_00_001100, 14'b011000_00_001000, 14'b110110_11_000000, 14'b111100_01_000000,
      14'b011001_11_000000, 14'b101101_11_000000, 14'b101111_11_000000, 14'b111000_00_000000,
      14'b111111_11_000000, 14'b111101_11_000000};
    nom  = '{19, 20, 9, 22, 5, 14, 13, 9, 2, 18, 15, 15};
    good = '{1, 28, 33, 37, 0, 27, 26, 12, 30, 8, 3, 24};

    do_reset();

    // Nominal frame: S T I V E N M I B R O O
    c0 = n_cv; c1 = n_fd;
    load_chars(nom);
    send_frame(1, -1);
    idle(4);
    chk("nom_char_count", n_cv - c0, 12);
    chk("nom_frame_count", n_fd - c1, 1);
    chk("nom_frame_ok", frame_ok, 1);
    chk("nom_frame_cnt", frame_cnt, 1);
    rd_idx = 4'd3;
    #1;
    chk("nom_rd3", rd_code, 22);

    // Held digits and a gap between digits 5 and 6
    c0 = n_cv; c1 = n_fd; c2 = n_eoh + n_esq;
    send_frame(3, 5);
    idle(4);
    chk("hold_char_count", n_cv - c0, 36);
    chk("hold_frame_count", n_fd - c1, 1);
    chk("hold_errors", n_eoh + n_esq - c2, 0);

    // Non-one-hot select at digit 4, then a normal frame
    load_chars(good);
    c1 = n_fd; c2 = n_eoh;
    for (int d = 0; d < 4; d++) drive(12'(1 << d), fp[d]);
    drive(12'h011, fp[4]);
    idle(4);
    chk("oh_err_count", n_eoh - c2, 1);
    chk("oh_no_frame", n_fd - c1, 0);
    rd_idx = 4'd0;
    #1;
    chk("oh_commit_kept", rd_code, 19);
    send_frame(1, -1);
    idle(4);
    chk("oh_next_frame", n_fd - c1, 1);

    // Sequence break 0,1,3 then 4..11 ignored
    c0 = n_cv; c1 = n_fd; c3 = n_esq;
    drive(12'h001, fp[0]);
    drive(12'h002, fp[1]);
    for (int d = 3; d < 12; d++) drive(12'(1 << d), fp[d]);
    idle(4);
    chk("seq_err_count", n_esq - c3, 1);
    chk("seq_char_count", n_cv - c0, 11);
    chk("seq_no_frame", n_fd - c1, 0);

    // Unknown glyph at digit 7
    c1 = n_fd;
    fp[7] = 14'h3FFF;
    send_frame(1, -1);
    idle(4);
    chk("unk_frame_count", n_fd - c1, 1);
    chk("unk_frame_ok", frame_ok, 0);
    rd_idx = 4'd7;
    #1;
    chk("unk_rd7", rd_code, 63);

    // Reset in the middle of frame 3, then 256 frames to wrap the counter
    load_chars(good);
    send_frame(1, -1);
    send_frame(1, -1);
    for (int d = 0; d < 7; d++) drive(12'(1 << d), fp[d]);
    do_reset();
    c1 = n_fd;
    for (int f = 0; f < 256; f++) send_frame(1, -1);
    idle(4);
    chk("wrap_frames", n_fd - c1, 256);
    chk("wrap_frame_cnt", frame_cnt, 0);

    // Randomized scans with holds, gaps, stray selects and raw patterns
    for (int r = 0; r < 40; r++) begin
      hold = $urandom_range(1, 2);
      for (int d = 0; d < 12; d++) begin
        c = $urandom_range(0, 37);
        p = ($urandom_range(0, 9) == 0) ? 14'($urandom) : font[c];
        mode = $urandom_range(0, 24);
        if (mode == 0) drive(12'($urandom), p);
        else if (mode == 1) drive(12'(1 << $urandom_range(0, 11)), p);
        else for (int h = 0; h < hold; h++) drive(12'(1 << d), p);
        if ($urandom_range(0, 7) == 0) drive('0, 14'($urandom));
      end
    end
    idle(6);
    chk("queue_drained", expq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg14_scan_decoder.md
# seg14_scan_decoder

Receive-side monitor for the 12-digit multiplexed 14-segment display bus. It samples the one-hot digit select `sel` and segment pattern `segm` and checks the scan order. Each glyph is decoded back into a 6-bit character code, and complete 12-digit frames are assembled into a readable buffer. It sits beside the display scan driver for on-chip readback and self-check of the displayed text.

## Interface
Parameters:
- `DIGITS`, 12, number of scanned digits (fixed at 12 in this revision)
- `SEG_W`, 14, segment bus width
- `CODE_W`, 6, character code width

Ports:
- `clk`  in  1  system clock; all logic on the rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `sel`  in  12  digit select from the scan driver; bit k = digit k
- `segm`  in  14  segment pattern; bit 13 = segment a, in font-table order
- `char_valid`  out  1  one-cycle strobe: a decoded digit is presented
- `char_idx`  out  4  digit index 0..11 for `char_code`
- `char_code`  out  6  decoded code
- `frame_done`  out  1  one-cycle strobe: digits 0..11 were captured in order
- `frame_ok`  out  1  the last completed frame had no unknown glyph; held until the next `frame_done`
- `err_onehot`  out  1  one-cycle strobe: `sel` was non-zero and not one-hot
- `err_seq`  out  1  one-cycle strobe: the scan index broke sequence
- `frame_cnt`  out  8  completed frames, wraps 255 -> 0
- `rd_idx`  in  4  read address into the committed buffer
- `rd_code`  out  6  committed code at `rd_idx`, combinational; 0 for `rd_idx` > 11

## Operation
- Code map:
  - space = 0
  - A..Z = 1..26
  - Ñ = 27
  - digits 0..9 = 28..37
  - any unmatched pattern = 63 (unknown)
- Decode is by exact 14-bit match against the font table. The pattern 10110111000000 is shared by S and 5 and decodes as S (19).
- Stage 1 registers `sel` and `segm`.
- Stage 2 classifies the registered `sel`:
  - zero = no digit (ignored)
  - one-hot = index k
  - anything else = one-hot error
- State machine:
  - HUNT: waits for k = 0. That digit is written to the shadow buffer, `last` is set to 0, and the FSM moves to CAPTURE. Any other k is ignored silently.
  - CAPTURE, k = `last`: the same digit is held. The shadow entry is overwritten and `char_valid` fires again.
  - CAPTURE, k = `last`+1: the entry is written and `last` becomes k. If k = 11, the shadow buffer is copied to the committed buffer, `frame_done` pulses, `frame_cnt` increments, `frame_ok` updates, and the FSM returns to HUNT.
  - CAPTURE, any other k: `err_seq` pulses and the FSM goes to HUNT. This includes a wrap to 0 before 11. The k = 0 digit is not re-used as a start.
  - CAPTURE, `sel` = 0: the FSM holds state with no strobe.
  - Non-one-hot in any state: `err_onehot` pulses, the FSM goes to HUNT, and the shadow buffer is discarded.
- `char_valid`, `char_idx` and `char_code` are emitted for every one-hot sample in both HUNT and CAPTURE.
- `frame_ok` is the AND over the 12 committed entries being != 63.
- The committed buffer changes only on `frame_done`. An aborted frame never reaches `rd_code`.

## Timing
- Reset values:
  - all strobes 0
  - `char_idx` / `char_code` 0
  - `frame_ok` 0
  - `frame_cnt` 0
  - both buffers all 0 (space)
  - FSM in HUNT
  - input registers 0
- Latency: `sel`/`segm` sampled at edge N drive `char_valid` / `err_*` / `frame_done` high from edge N+2 for exactly one cycle.
- `rd_code` reflects the new frame from edge N+2, in the same cycle as `frame_done`.
- Back-to-back frames are supported, so one digit per cycle gives a `frame_done` every 12 cycles.
- Reset asserted mid-frame clears everything asynchronously. The first frame after release starts at the next k = 0.

## Structure
- `seg14_pkg`: `DIGITS`, `SEG_W`, `CODE_W`, the code constants (`CODE_SPACE`, `CODE_UNKNOWN`, …) and the 14-segment font table shared with the scan driver.
- Sub-module `seg14_glyph_decode`: purely combinational `segm` -> code lookup, instantiated once in stage 2.
- Top: input registers, one-hot classifier, FSM, shadow/committed buffers, counters.

## Test plan
- **Nominal frame.** Drive digits 0..11 one per cycle with glyphs S T I V E N M I B R O O.
  - Twelve `char_valid` strobes with codes 19, 20, 9, 22, 5, 14, 13, 9, 2, 18, 15, 15.
  - `frame_done` with the digit-11 strobe, `frame_ok` = 1, `frame_cnt` = 1.
  - `rd_idx` = 3 gives 22.
- **Hold and gaps.** Same frame, with each digit held 3 cycles and `sel` = 0 inserted between digits 5 and 6.
  - 36 `char_valid` strobes, one `frame_done`, no errors.
- **One-hot error.** At digit 4, `sel` = 12'h011.
  - `err_onehot` pulse, no `frame_done`, committed buffer unchanged.
  - The following full frame completes normally.
- **Sequence error.** Digits 0, 1, 3.
  - `err_seq` on digit 3, FSM in HUNT.
  - Digits 4..11 ignored (`char_valid` only, no `frame_done`).
- **Unknown glyph.** Digit 7 carries `segm` = 14'h3FFF.
  - `char_code` = 63 for digit 7, `frame_done` fires, `frame_ok` = 0.
- **Reset and counter.** Assert `rst_n` low at digit 6 of frame 3.
  - All outputs return to 0 and `rd_code` reads 0 everywhere.
  - Then run 256 good frames: `frame_cnt` wraps to 0.
